// File: rtl/product_accumulator.sv
// product_accumulator
// Sums a programmed number of signed products received over a valid/ready
// handshake and presents one saturated signed result per job. The running
// sum carries LEN_W guard bits so it cannot wrap within a job; clamping to
// OUT_W happens only when the final term is added.
module product_accumulator #(
    parameter int PROD_W = 64,
    parameter int LEN_W  = 8,
    parameter int OUT_W  = 64
) (
    input  logic              clk,
    input  logic              rst,          // asynchronous, active-low
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [OUT_W-1:0]  acc_out,
    output logic              ovf,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int ACC_W = PROD_W + LEN_W;
    localparam int EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    // Output range limits expressed in the comparison width
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'($signed({1'b0, {(OUT_W-1){1'b1}}}));
    localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'($signed({1'b1, {(OUT_W-1){1'b0}}}));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic signed [ACC_W-1:0]  r_acc;
    logic [LEN_W-1:0]         r_cnt;
    logic [LEN_W-1:0]         r_len_q;
    logic [OUT_W-1:0]         r_acc_out;
    logic                     r_ovf;

    logic                     w_start_job;
    logic                     w_start_empty;
    logic                     w_xfer;
    logic                     w_last;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [EXT_W-1:0]  w_sum_ext;
    logic                     w_sat_hi;
    logic                     w_sat_lo;
    logic [OUT_W-1:0]         w_sat_val;

    assign w_start_job   = (r_state == S_IDLE) && start && (len != '0);
    assign w_start_empty = (r_state == S_IDLE) && start && (len == '0);
    assign w_xfer        = (r_state == S_ACCUM) && prod_valid;
    assign w_last        = w_xfer && (r_cnt == (r_len_q - LEN_W'(1)));

    // Sign-extend the incoming product into the guard-bit accumulator width
    assign w_prod_ext = $signed({{LEN_W{prod_in[PROD_W-1]}}, prod_in});
    assign w_sum      = r_acc + w_prod_ext;
    assign w_sum_ext  = EXT_W'(w_sum);
    assign w_sat_hi   = (w_sum_ext > SAT_MAX);
    assign w_sat_lo   = (w_sum_ext < SAT_MIN);
    assign w_sat_val  = w_sat_hi ? SAT_MAX[OUT_W-1:0] :
                        w_sat_lo ? SAT_MIN[OUT_W-1:0] :
                                   w_sum_ext[OUT_W-1:0];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: a job runs IDLE -> ACCUM -> DONE, empty jobs skip ACCUM
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_job) begin
                    w_state_next = S_ACCUM;
                end else if (w_start_empty) begin
                    w_state_next = S_DONE;
                end
            end
            S_ACCUM: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Handshake outputs are pure functions of the registered state
    always_comb begin
        busy       = (r_state != S_IDLE);
        prod_ready = (r_state == S_ACCUM);
        out_valid  = (r_state == S_DONE);
    end

    // Running sum, term counter and latched job length
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_len_q <= '0;
        end else if (w_start_job) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_len_q <= len;
        end else if (w_xfer) begin
            r_acc   <= w_sum;
            r_cnt   <= r_cnt + LEN_W'(1);
        end
    end

    // Result register: loaded on the final term or on an empty job, held through DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc_out <= '0;
            r_ovf     <= 1'b0;
        end else if (w_start_empty) begin
            r_acc_out <= '0;
            r_ovf     <= 1'b0;
        end else if (w_last) begin
            r_acc_out <= w_sat_val;
            r_ovf     <= w_sat_hi | w_sat_lo;
        end
    end

    assign acc_out = r_acc_out;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Testbench for product_accumulator: directed cases plus random jobs,
// checked by a scoreboard fed from a plain-arithmetic reference model.
module tb_product_accumulator;

    localparam int PW = 64;
    localparam int LW = 8;
    localparam int OW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          busy;
    logic [PW-1:0] prod_in = '0;
    logic          prod_valid = 1'b0;
    logic          prod_ready;
    logic [OW-1:0] acc_out;
    logic          ovf;
    logic          out_valid;
    logic          out_ready = 1'b1;

    product_accumulator #(.PROD_W(PW), .LEN_W(LW), .OUT_W(OW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .acc_out    (acc_out),
        .ovf        (ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] v;
        logic        o;
    } exp_t;

    exp_t                sb[$];
    logic signed [63:0]  pq[$];
    int                  tests_run = 0;
    int                  failures  = 0;

    localparam logic signed [127:0] MAXV = 128'sd9223372036854775807;
    localparam logic signed [127:0] MINV = -128'sd9223372036854775808;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every result handshake is compared against the oldest expectation
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests_run++;
                failures++;
                $display("[TB] FAIL unexpected_result: got acc_out=%0h with empty scoreboard", acc_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("acc_out", {64'd0, acc_out}, {64'd0, e.v});
                check("ovf", {127'd0, ovf}, {127'd0, e.o});
                $display("[TB] result acc_out=%0d ovf=%0b (expected %0d/%0b)",
                         $signed(acc_out), ovf, $signed(e.v), e.o);
            end
        end
    end

    // Present one product and hold it until the DUT accepts it
    task automatic send_prod(input logic signed [63:0] v);
        int t = 0;
        prod_in    = v;
        prod_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (prod_ready) break;
            t++;
            if (t > 100) begin
                tests_run++;
                failures++;
                $display("[TB] FAIL prod_ready_timeout: got 0, expected 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        prod_valid = 1'b0;
        prod_in    = {$urandom, $urandom};
    endtask

    task automatic wait_idle();
        int t = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            t++;
            if (t > 200) begin
                tests_run++;
                failures++;
                $display("[TB] FAIL idle_timeout: busy got 1, expected 0");
                break;
            end
        end
    endtask

    // Run one job built from pq: model result pushed, products streamed, result drained
    task automatic run_job(input int gap_max, input int hold);
        logic signed [127:0] s;
        exp_t e;
        int   n;
        int   gaps;
        n = pq.size();
        s = '0;
        foreach (pq[i]) s = s + pq[i];
        if (s > MAXV)      begin e.v = 64'h7FFF_FFFF_FFFF_FFFF; e.o = 1'b1; end
        else if (s < MINV) begin e.v = 64'h8000_0000_0000_0000; e.o = 1'b1; end
        else               begin e.v = s[63:0];                 e.o = 1'b0; end
        sb.push_back(e);
        $display("[TB] job len=%0d gap_max=%0d hold=%0d expect %0d ovf=%0b",
                 n, gap_max, hold, $signed(e.v), e.o);

        @(negedge clk);
        check("idle_prod_ready", {127'd0, prod_ready}, 128'd0);
        @(posedge clk);
        #1;
        out_ready = (hold == 0);
        start     = 1'b1;
        len       = LW'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        len   = LW'($urandom);
        if (n == 0) begin
            check("empty_out_valid", {127'd0, out_valid}, 128'd1);
            check("empty_prod_ready", {127'd0, prod_ready}, 128'd0);
        end
        for (int i = 0; i < n; i++) begin
            gaps = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            for (int g = 0; g < gaps; g++) begin
                @(negedge clk);
                check("gap_prod_ready", {127'd0, prod_ready}, 128'd1);
                check("gap_no_result", {127'd0, out_valid}, 128'd0);
                @(posedge clk);
                #1;
            end
            send_prod(pq[i]);
        end
        if (n > 0) check("result_latency", {127'd0, out_valid}, 128'd1);
        for (int k = 0; k < hold; k++) begin
            start = 1'b1;
            len   = 8'd5;
            @(negedge clk);
            check("hold_out_valid", {127'd0, out_valid}, 128'd1);
            check("hold_acc_out", {64'd0, acc_out}, {64'd0, e.v});
            check("hold_prod_ready", {127'd0, prod_ready}, 128'd0);
            @(posedge clk);
            #1;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        @(negedge clk);
        check("post_idle_busy", {127'd0, busy}, 128'd0);
        pq.delete();
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_prod_ready", {127'd0, prod_ready}, 128'd0);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_acc_out", {64'd0, acc_out}, 128'd0);
        check("rst_ovf", {127'd0, ovf}, 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // T1: back-to-back products
        pq.push_back(64'sd10); pq.push_back(-64'sd10); pq.push_back(64'sd660);
        run_job(0, 0);

        // T2: positive and negative saturation
        for (int i = 0; i < 3; i++) pq.push_back(64'sd4611686014132420609);
        run_job(0, 0);
        for (int i = 0; i < 3; i++) pq.push_back(-64'sd4611686018427387904);
        run_job(0, 0);

        // T3: gaps between products
        pq.push_back(64'sd1); pq.push_back(-64'sd1); pq.push_back(64'sd5); pq.push_back(-64'sd660);
        run_job(2, 0);

        // T4: result backpressure with start pulses ignored
        pq.push_back(64'sd123); pq.push_back(-64'sd23);
        run_job(0, 5);

        // T5: empty job
        run_job(0, 0);

        // T6: asynchronous reset mid-job, then a clean job
        @(posedge clk);
        #1;
        start = 1'b1;
        len   = 8'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_prod(64'sd7);
        send_prod(64'sd9);
        #2;
        rst = 1'b0;
        #1;
        check("arst_busy", {127'd0, busy}, 128'd0);
        check("arst_prod_ready", {127'd0, prod_ready}, 128'd0);
        check("arst_out_valid", {127'd0, out_valid}, 128'd0);
        check("arst_acc_out", {64'd0, acc_out}, 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        pq.push_back(-64'sd5);
        run_job(0, 0);

        // Maximum job length
        for (int i = 0; i < 255; i++) pq.push_back($signed({$urandom, $urandom}));
        run_job(0, 0);

        // Random jobs
        for (int j = 0; j < 25; j++) begin
            int n;
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) begin
                case ($urandom % 3)
                    0: pq.push_back($signed({$urandom, $urandom}));
                    1: pq.push_back(64'($signed($urandom_range(0, 2000)) - 1000));
                    default: pq.push_back(($urandom % 2) ? 64'sh7FFF_FFFF_0000_0000
                                                         : -64'sh7FFF_FFFF_0000_0000);
                endcase
            end
            run_job($urandom_range(0, 2), $urandom_range(0, 2));
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
